// File: rtl/fingerprint_recorder.sv
// Records one mean-removed fingerprint window into a matched_filter RAM.
// Latency: CAPTURE_LENGTH + SUM_WIDTH + CAPTURE_LENGTH + 2 cycles from arm to done.
// Backpressure: none. A sample-valid gap restarts the window. Arm is ignored while busy.
module fingerprint_recorder #(
  parameter  int SAMPLE_DATA_WIDTH = 8,
  parameter  int CAPTURE_LENGTH    = 1000,
  localparam int ADDR_WIDTH        = $clog2(CAPTURE_LENGTH)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                axiiv,
  input  logic        [SAMPLE_DATA_WIDTH-1:0] axiid,
  input  logic                                arm,
  output logic        [ADDR_WIDTH-1:0]        ram_write_addr,
  output logic signed [SAMPLE_DATA_WIDTH-1:0] ram_write_data,
  output logic                                ram_write_enable,
  output logic                                busy,
  output logic                                done
);

  localparam int SUM_WIDTH     = SAMPLE_DATA_WIDTH + $clog2(CAPTURE_LENGTH + 1);
  // The shared counter indexes samples in CAPTURE and steps through the
  // read/write pipeline in WRITE, which needs two cycles past the last index.
  localparam int CNT_WIDTH     = $clog2(CAPTURE_LENGTH + 2);
  localparam int DIV_CNT_WIDTH = $clog2(SUM_WIDTH + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DIVIDE  = 2'd2;
  localparam logic [1:0] ST_WRITE   = 2'd3;

  localparam logic [CNT_WIDTH-1:0]     CNT_LAST_SAMPLE = CNT_WIDTH'(CAPTURE_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0]     CNT_LENGTH      = CNT_WIDTH'(CAPTURE_LENGTH);
  localparam logic [CNT_WIDTH-1:0]     CNT_FINISH      = CNT_WIDTH'(CAPTURE_LENGTH + 1);
  localparam logic [DIV_CNT_WIDTH-1:0] DIV_LAST        = DIV_CNT_WIDTH'(SUM_WIDTH - 1);
  localparam logic [SUM_WIDTH-1:0]     DIVISOR         = SUM_WIDTH'(CAPTURE_LENGTH);

  localparam logic signed [SAMPLE_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(SAMPLE_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SAMPLE_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(SAMPLE_DATA_WIDTH-1){1'b0}}};

  // Control and datapath state
  logic [1:0]                    state_q,    state_d;
  logic [CNT_WIDTH-1:0]          count_q,    count_d;
  logic [SUM_WIDTH-1:0]          sum_q,      sum_d;
  logic [SUM_WIDTH-1:0]          rem_q,      rem_d;
  logic [DIV_CNT_WIDTH-1:0]      div_cnt_q,  div_cnt_d;
  logic [SAMPLE_DATA_WIDTH-1:0]  mean_q,     mean_d;
  logic                          busy_q,     busy_d;
  logic                          done_q,     done_d;
  logic                          rd_vld_q,   rd_vld_d;
  logic [ADDR_WIDTH-1:0]         rd_idx_q,   rd_idx_d;
  logic                          wr_en_q,    wr_en_d;
  logic [ADDR_WIDTH-1:0]         wr_addr_q,  wr_addr_d;
  logic signed [SAMPLE_DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  // Sample buffer (block RAM, registered read)
  logic [SAMPLE_DATA_WIDTH-1:0]  sample_mem [CAPTURE_LENGTH];
  logic [SAMPLE_DATA_WIDTH-1:0]  buf_rdata_q;
  logic                          buf_we;
  logic [ADDR_WIDTH-1:0]         buf_waddr;
  logic                          buf_re;
  logic [ADDR_WIDTH-1:0]         buf_raddr;

  // Divider and subtract/saturate helpers
  logic [SUM_WIDTH:0]                  rem_shift;
  logic                                q_bit;
  logic signed [SAMPLE_DATA_WIDTH:0]   diff;
  logic signed [SAMPLE_DATA_WIDTH-1:0] diff_sat;

  // Sample buffer: written during capture, read one word per cycle during write-out
  always_ff @(posedge clk) begin
    if (buf_we) begin
      sample_mem[buf_waddr] <= axiid;
    end
    if (buf_re) begin
      buf_rdata_q <= sample_mem[buf_raddr];
    end
  end

  // Mean removal with clamping to the signed fingerprint range
  always_comb begin
    diff = $signed({1'b0, buf_rdata_q}) - $signed({1'b0, mean_q});
    diff_sat = diff[SAMPLE_DATA_WIDTH-1:0];
    // Top two bits disagree only when the difference leaves the W-bit signed range.
    if (diff[SAMPLE_DATA_WIDTH] != diff[SAMPLE_DATA_WIDTH-1]) begin
      diff_sat = diff[SAMPLE_DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    rem_shift = {rem_q, sum_q[SUM_WIDTH-1]};
    q_bit     = (rem_shift >= {1'b0, DIVISOR});
  end

  // Next-state logic for the recorder FSM and the write-out pipeline
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sum_d     = sum_q;
    rem_d     = rem_q;
    div_cnt_d = div_cnt_q;
    mean_d    = mean_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_vld_d  = 1'b0;
    rd_idx_d  = rd_idx_q;
    buf_we    = 1'b0;
    buf_waddr = count_q[ADDR_WIDTH-1:0];
    buf_re    = 1'b0;
    buf_raddr = count_q[ADDR_WIDTH-1:0];

    // Output stage: the word read last cycle is written to the filter RAM now.
    wr_en_d   = rd_vld_q;
    wr_addr_d = rd_vld_q ? rd_idx_q : wr_addr_q;
    wr_data_d = rd_vld_q ? diff_sat : wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_CAPTURE;
          count_d = '0;
          sum_d   = '0;
          busy_d  = 1'b1;
        end
      end

      ST_CAPTURE: begin
        if (axiiv) begin
          buf_we  = 1'b1;
          sum_d   = sum_q + SUM_WIDTH'(axiid);
          count_d = count_q + 1'b1;
          if (count_q == CNT_LAST_SAMPLE) begin
            state_d   = ST_DIVIDE;
            rem_d     = '0;
            div_cnt_d = '0;
          end
        end else if (count_q != '0) begin
          // A gap in the stream invalidates the partial window.
          count_d = '0;
          sum_d   = '0;
        end
      end

      ST_DIVIDE: begin
        // Quotient bits shift into sum from the bottom as dividend bits leave the top.
        rem_d     = q_bit ? (rem_shift[SUM_WIDTH-1:0] - DIVISOR) : rem_shift[SUM_WIDTH-1:0];
        sum_d     = {sum_q[SUM_WIDTH-2:0], q_bit};
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == DIV_LAST) begin
          state_d = ST_WRITE;
          mean_d  = sum_d[SAMPLE_DATA_WIDTH-1:0];
          count_d = '0;
        end
      end

      ST_WRITE: begin
        count_d = count_q + 1'b1;
        if (count_q < CNT_LENGTH) begin
          buf_re   = 1'b1;
          rd_vld_d = 1'b1;
          rd_idx_d = count_q[ADDR_WIDTH-1:0];
        end
        if (count_q == CNT_FINISH) begin
          // Last word was registered on the previous edge.
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          count_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset clears everything and stops writes immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      sum_q     <= '0;
      rem_q     <= '0;
      div_cnt_q <= '0;
      mean_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      rem_q     <= rem_d;
      div_cnt_q <= div_cnt_d;
      mean_q    <= mean_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_vld_q  <= rd_vld_d;
      rd_idx_q  <= rd_idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign ram_write_addr   = wr_addr_q;
  assign ram_write_data   = wr_data_q;
  assign ram_write_enable = wr_en_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_fingerprint_recorder.sv
// Bench for fingerprint_recorder with W=8, N=4 (SUM_WIDTH=11).
// A window-level model predicts busy/done/write timing and data every cycle;
// literal expectations from hand calculation pin the model per case.
module tb_fingerprint_recorder;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = W + $clog2(N + 1);

  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic              axiiv = 1'b0;
  logic [W-1:0]      axiid = '0;
  logic              arm   = 1'b0;
  logic [1:0]        ram_write_addr;
  logic signed [W-1:0] ram_write_data;
  logic              ram_write_enable;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  fingerprint_recorder #(
    .SAMPLE_DATA_WIDTH(W),
    .CAPTURE_LENGTH(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .axiiv(axiiv),
    .axiid(axiid),
    .arm(arm),
    .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data),
    .ram_write_enable(ram_write_enable),
    .busy(busy),
    .done(done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- window-level model ----------------
  int ecnt      = 0;   // number of rising edges seen
  bit m_busy    = 0;
  bit m_cap     = 0;
  bit m_pending = 0;
  int m_base    = 0;   // edge at which the window completed
  int win[$];
  int exp_data[N];

  always @(posedge clk) begin : model
    int sum;
    int mean;
    int d;
    ecnt++;
    if (!rst) begin
      if (!m_busy && arm) begin
        m_busy = 1;
        m_cap  = 1;
        win.delete();
      end else if (m_cap) begin
        if (axiiv) begin
          win.push_back(int'(axiid));
          if (win.size() == N) begin
            sum = 0;
            foreach (win[i]) sum += win[i];
            mean = sum / N;
            for (int k = 0; k < N; k++) begin
              d = win[k] - mean;
              if (d > 127) d = 127;
              if (d < -128) d = -128;
              exp_data[k] = d;
            end
            m_base    = ecnt;
            m_cap     = 0;
            m_pending = 1;
          end
        end else begin
          win.delete();
        end
      end
      if (m_pending && ecnt == m_base + S + N + 2) m_busy = 0;
    end
  end

  always @(posedge rst) begin
    m_busy    = 0;
    m_cap     = 0;
    m_pending = 0;
    win.delete();
  end

  // ---------------- per-cycle compare ----------------
  int act_addr[$];
  int act_data[$];
  int done_cnt  = 0;
  int done_edge = -1;
  int arm_edge  = 0;

  always @(negedge clk) begin : compare
    int off;
    bit exp_we;
    bit exp_done;
    off      = ecnt - m_base;
    exp_we   = m_pending && (off >= S + 2) && (off <= S + N + 1);
    exp_done = m_pending && (off == S + N + 2);
    check("busy", int'(busy), int'(m_busy));
    check("done", int'(done), int'(exp_done));
    check("wr_en", int'(ram_write_enable), int'(exp_we));
    if (exp_we && ram_write_enable) begin
      check("wr_addr", int'(ram_write_addr), off - S - 2);
      check("wr_data", int'($signed(ram_write_data)), exp_data[off - S - 2]);
    end
    if (ram_write_enable) begin
      act_addr.push_back(int'(ram_write_addr));
      act_data.push_back(int'($signed(ram_write_data)));
    end
    if (done) begin
      done_cnt++;
      done_edge = ecnt;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm_edge = ecnt;
    arm = 1'b0;
  endtask

  task automatic send(input bit v, input int d);
    axiiv = v;
    axiid = W'(d);
    tick();
    axiiv = 1'b0;
  endtask

  task automatic start_case();
    act_addr.delete();
    act_data.delete();
    done_cnt  = 0;
    done_edge = -1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      tick();
      n++;
    end
    if (done_cnt == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done, required done within 200 cycles", name);
    end
    repeat (3) tick();
  endtask

  task automatic check_log(input string name, input int e0, input int e1,
                           input int e2, input int e3, input int lat);
    int e[4];
    e = '{e0, e1, e2, e3};
    check({name, "_nwrites"}, act_data.size(), 4);
    check({name, "_ndone"}, done_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < act_data.size()) begin
        check({name, "_addr"}, act_addr[i], i);
        check({name, "_data"}, act_data[i], e[i]);
      end
    end
    if (lat >= 0) check({name, "_latency"}, done_edge - arm_edge, lat);
  endtask

  task automatic run4(input int a, input int b, input int c, input int d);
    send(1, a);
    send(1, b);
    send(1, c);
    send(1, d);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int n;
    rst = 1'b1;
    tick();
    tick();
    check("rst_addr", int'(ram_write_addr), 0);
    check("rst_data", int'(ram_write_data), 0);
    check("rst_wr_en", int'(ram_write_enable), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    tick();

    // Mean removal
    start_case();
    arm_pulse();
    run4(10, 20, 30, 40);
    wait_done("mean");
    check_log("mean", -15, -5, 5, 15, 21);

    // Saturation
    start_case();
    arm_pulse();
    run4(0, 0, 0, 255);
    wait_done("sat");
    check_log("sat", -63, -63, -63, 127, 21);

    // Window break
    start_case();
    arm_pulse();
    send(1, 10);
    send(1, 20);
    send(0, 99);
    run4(1, 2, 3, 4);
    wait_done("break");
    check_log("break", -1, 0, 1, 2, 24);

    // Constant input
    start_case();
    arm_pulse();
    run4(200, 200, 200, 200);
    wait_done("const");
    check_log("const", 0, 0, 0, 0, 21);

    // Arm while busy (during divide)
    start_case();
    arm_pulse();
    run4(10, 20, 30, 40);
    repeat (3) tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    wait_done("armbusy");
    repeat (30) tick();
    check_log("armbusy", -15, -5, 5, 15, 21);

    // Async reset mid-write
    start_case();
    arm_pulse();
    run4(10, 20, 30, 40);
    n = 0;
    while (!ram_write_enable && n < 60) begin
      tick();
      n++;
    end
    check("rstmid_write_seen", int'(ram_write_enable), 1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_wr_en", int'(ram_write_enable), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_done", int'(done), 0);
    tick();
    rst = 1'b0;
    tick();

    // Recovery after reset
    start_case();
    arm_pulse();
    run4(10, 20, 30, 40);
    wait_done("rearm");
    check_log("rearm", -15, -5, 5, 15, 21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL global_timeout: simulation did not complete, required completion before 100000 time units");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule

// File: doc/fingerprint_recorder.md
# fingerprint_recorder

Captures one CAPTURE_LENGTH-sample window from the sample stream, removes its mean and writes the zero-mean signed result into a `matched_filter` instance through its fingerprint RAM write port (`ram_write_addr` / `ram_write_data` / `ram_write_enable`). It is the writer side of that port and enables training new fingerprints at runtime instead of relying only on `FINGERPRINT_MEMORY_FILE`. Sits beside the matched filter on the same sample stream.

## Interface
- SAMPLE_DATA_WIDTH, 8: width of unsigned input samples and of signed fingerprint words.
- CAPTURE_LENGTH, 1000: samples per fingerprint; must match the target filter.
- ADDR_WIDTH (localparam) = $clog2(CAPTURE_LENGTH); SUM_WIDTH (localparam) = SAMPLE_DATA_WIDTH + $clog2(CAPTURE_LENGTH + 1).

- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- axiiv  in  1  sample valid; a low cycle breaks the capture window.
- axiid  in  SAMPLE_DATA_WIDTH  unsigned sample.
- arm  in  1  single-cycle request to record a fingerprint; ignored unless idle.
- ram_write_addr  out  ADDR_WIDTH  fingerprint RAM address.
- ram_write_data  out  SAMPLE_DATA_WIDTH, signed  mean-removed sample.
- ram_write_enable  out  1  write strobe to the filter RAM.
- busy  out  1  high from the cycle after an accepted arm until done.
- done  out  1  one-cycle pulse when the last word has been written.

## Operation
- Internal sample buffer: CAPTURE_LENGTH x SAMPLE_DATA_WIDTH, inferred block RAM, 1-cycle read latency.
- States: IDLE, CAPTURE, DIVIDE, WRITE. rst, asserted at any time, forces IDLE immediately.
- IDLE: when arm=1, go to CAPTURE and clear count and sum. busy=0.
- CAPTURE: on each cycle with axiiv=1, store axiid at buffer[count], add it to sum (SUM_WIDTH, unsigned) and increment count. If axiiv=0 while 0 < count < CAPTURE_LENGTH, reset count and sum to 0 and stay in CAPTURE so that the window restarts; the same break semantics as the filter's summing state. When count reaches CAPTURE_LENGTH, go to DIVIDE.
- DIVIDE: restoring divider with one quotient bit per cycle; mean = floor(sum / CAPTURE_LENGTH). Takes exactly SUM_WIDTH cycles, then go to WRITE. No combinational divider.
- WRITE: read buffer[k] for k = 0..CAPTURE_LENGTH-1 on consecutive cycles. One cycle later, compute diff = buffer[k] - mean in SAMPLE_DATA_WIDTH+1 signed bits.
- Saturate diff to [-2^(SAMPLE_DATA_WIDTH-1), 2^(SAMPLE_DATA_WIDTH-1)-1] and drive it on ram_write_data, with ram_write_addr=k and ram_write_enable=1.
- After the last write, pulse done for one cycle and go to IDLE.
- axiiv/axiid are ignored outside CAPTURE. arm is ignored while busy. Arm pulses are not queued.

## Timing
- Reset values: ram_write_addr=0, ram_write_data=0, ram_write_enable=0, busy=0, done=0. The state, count, sum and mean are also cleared.
- Arm accepted on edge T: busy=1 from T+1, and the first sample can be accepted on edge T+1.
- With an unbroken window, the Nth sample is accepted at edge T+N. DIVIDE then occupies SUM_WIDTH cycles.
- WRITE phase timing: ram_write_enable is high for exactly CAPTURE_LENGTH consecutive cycles, starting 1 cycle after WRITE is entered. Addresses ascend by 1 with no gaps.
- done=1 in the cycle after the last write. busy falls in that same cycle.
- Total latency with unbroken input is CAPTURE_LENGTH + SUM_WIDTH + CAPTURE_LENGTH + 2 cycles from arm to done.
- ram_write_enable is never high outside WRITE, including during reset.
- Reset mid-WRITE: writes stop asynchronously and a partial fingerprint remains in the filter RAM. Recovery requires a new arm.
- All outputs are registered.

## Test plan
- Mean removal (W=8, N=4, SUM_WIDTH=11): arm, then samples 10,20,30,40 -> writes -15,-5,5,15 to addrs 0..3 on 4 consecutive cycles, then done. Total arm-to-done is 21 cycles.
- Saturation: samples 0,0,0,255 (mean 63) -> writes -63,-63,-63,127, with 127 being the clamped value of 192.
- Window break: samples 10,20, then axiiv low for 1 cycle, then 1,2,3,4 (mean floor(10/4)=2) -> writes -1,0,1,2.
- Constant input: samples 200,200,200,200 -> four writes of 0 to addrs 0..3.
- Arm while busy: a second arm pulse during DIVIDE -> no effect. Exactly one done pulse and exactly 4 writes.
- Async reset: assert rst between clock edges during WRITE -> ram_write_enable, busy and done go low immediately. The next arm performs a complete, correct recording.
